// File: rtl/flag_counter_pkg.sv
// Shared defaults for the periodic flag counter and a width helper for instantiators.
package flag_counter_pkg;

  localparam int DEF_N_BIT = 5;
  localparam int DEF_DUMP  = 10;

  // Smallest counter width able to hold 0..modulus-1 (at least one bit).
  function automatic int cnt_width(input int modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/flag_counter_mod_n_counter.sv
// Modulo-MOD enabled counter; tc is high while the count sits at MOD-1.
module mod_n_counter #(
  parameter int N_BIT = 5,
  parameter int MOD   = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tc
);

  localparam logic [N_BIT-1:0] LAST = N_BIT'(MOD - 1);

  logic [N_BIT-1:0] count_q;
  logic [N_BIT-1:0] count_d;

  assign tc = (count_q == LAST);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (enable) begin
      count_d = tc ? '0 : count_q + N_BIT'(1);
    end
  end

  // NOTE: reset is sampled on the clock edge (synchronous); state updates use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/flag_counter.sv
// Periodic one-cycle strobe every DUMP enabled cycles of the clk_p/clk_n pair.
module flag_counter
  import flag_counter_pkg::*;
#(
  parameter int N_BIT = DEF_N_BIT,
  parameter int DUMP  = DEF_DUMP
) (
  input  logic clk_p,
  input  logic clk_n,
  input  logic rst_n,
  input  logic enable,
  output logic flag_count
);

  if (DUMP < 2 || DUMP > (1 << N_BIT)) begin : g_bad_params
    $fatal(1, "flag_counter: DUMP=%0d is illegal for N_BIT=%0d", DUMP, N_BIT);
  end

  logic tc;
  logic flag_count_q;
  logic flag_count_d;

  mod_n_counter #(
    .N_BIT (N_BIT),
    .MOD   (DUMP)
  ) u_counter (
    .clk    (clk_p),
    .rst_n  (rst_n),
    .enable (enable),
    .tc     (tc)
  );

  // The wrap edge is exactly the enabled edge taken while at terminal count.
  assign flag_count_d = tc & enable;

  always_ff @(posedge clk_p) begin
    if (!rst_n) begin
      flag_count_q <= 1'b0;
    end else begin
      flag_count_q <= flag_count_d;
    end
  end

  assign flag_count = flag_count_q;

  // clk_n carries no state; it only has to be the complement of clk_p.
  a_clk_pair : assert property (@(posedge clk_p) clk_n !== clk_p)
    else $error("flag_counter: clk_n equals clk_p");

endmodule

// File: tb/tb_flag_counter.sv
// Directed bench for flag_counter: default 5-bit/10 instance plus a full-range 4-bit/16 instance.
module tb_flag_counter;

  logic clk_p = 1'b0;
  logic clk_n;
  logic rst_n, enable, flag;
  logic rst2_n, enable2, flag2;

  int n_cmp = 0;
  int n_err = 0;

  assign clk_n = ~clk_p;
  always #5 clk_p = ~clk_p;

  flag_counter dut (
    .clk_p      (clk_p),
    .clk_n      (clk_n),
    .rst_n      (rst_n),
    .enable     (enable),
    .flag_count (flag)
  );

  flag_counter #(.N_BIT(4), .DUMP(16)) dut16 (
    .clk_p      (clk_p),
    .clk_n      (clk_n),
    .rst_n      (rst2_n),
    .enable     (enable2),
    .flag_count (flag2)
  );

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    tick();
    rst_n  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 2; i++) tick();
    n_cmp++;
    if (flag !== 1'b0) begin
      n_err++; $display("FAIL reset_flag: got %b want 0", flag);
    end
    n_cmp++;
    if (dut.u_counter.count_q !== 5'd0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", dut.u_counter.count_q);
    end
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if (flag !== 1'b0 || dut.u_counter.count_q !== 5'd0) begin
        n_err++;
        $display("FAIL reset_with_enable[%0d]: got flag=%b count=%0d want flag=0 count=0",
                 i, flag, dut.u_counter.count_q);
      end
    end
  endtask

  task automatic test_continuous();
    rst_n  = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      logic       exp_flag;
      logic [4:0] exp_cnt;
      tick();
      exp_flag = (k % 10 == 0);
      exp_cnt  = 5'(k % 10);
      n_cmp++;
      if (flag !== exp_flag || dut.u_counter.count_q !== exp_cnt) begin
        n_err++;
        $display("FAIL continuous[edge %0d]: got flag=%b count=%0d want flag=%b count=%0d",
                 k, flag, dut.u_counter.count_q, exp_flag, exp_cnt);
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if (dut.u_counter.count_q !== 5'd6) begin
      n_err++; $display("FAIL pause_pre: got count=%0d want 6", dut.u_counter.count_q);
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (flag !== 1'b0 || dut.u_counter.count_q !== 5'd6) begin
        n_err++;
        $display("FAIL pause_hold[%0d]: got flag=%b count=%0d want flag=0 count=6",
                 i, flag, dut.u_counter.count_q);
      end
    end
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      logic       exp_flag;
      logic [4:0] exp_cnt;
      tick();
      exp_flag = (k == 4);
      exp_cnt  = 5'((6 + k) % 10);
      n_cmp++;
      if (flag !== exp_flag || dut.u_counter.count_q !== exp_cnt) begin
        n_err++;
        $display("FAIL pause_resume[edge %0d]: got flag=%b count=%0d want flag=%b count=%0d",
                 k, flag, dut.u_counter.count_q, exp_flag, exp_cnt);
      end
    end
  endtask

  task automatic test_enable_drop_at_terminal();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (flag !== 1'b0 || dut.u_counter.count_q !== 5'd9) begin
        n_err++;
        $display("FAIL drop_hold[%0d]: got flag=%b count=%0d want flag=0 count=9",
                 i, flag, dut.u_counter.count_q);
      end
    end
    enable = 1'b1;
    tick();
    n_cmp++;
    if (flag !== 1'b1 || dut.u_counter.count_q !== 5'd0) begin
      n_err++;
      $display("FAIL drop_wrap: got flag=%b count=%0d want flag=1 count=0",
               flag, dut.u_counter.count_q);
    end
    tick();
    n_cmp++;
    if (flag !== 1'b0 || dut.u_counter.count_q !== 5'd1) begin
      n_err++;
      $display("FAIL drop_after: got flag=%b count=%0d want flag=0 count=1",
               flag, dut.u_counter.count_q);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (flag !== 1'b0 || dut.u_counter.count_q !== 5'd0) begin
      n_err++;
      $display("FAIL mid_reset: got flag=%b count=%0d want flag=0 count=0",
               flag, dut.u_counter.count_q);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      logic       exp_flag;
      logic [4:0] exp_cnt;
      tick();
      exp_flag = (k == 10);
      exp_cnt  = 5'(k % 10);
      n_cmp++;
      if (flag !== exp_flag || dut.u_counter.count_q !== exp_cnt) begin
        n_err++;
        $display("FAIL mid_resume[edge %0d]: got flag=%b count=%0d want flag=%b count=%0d",
                 k, flag, dut.u_counter.count_q, exp_flag, exp_cnt);
      end
    end
  endtask

  task automatic test_full_range();
    rst2_n  = 1'b0;
    enable2 = 1'b0;
    tick();
    n_cmp++;
    if (flag2 !== 1'b0 || dut16.u_counter.count_q !== 4'd0) begin
      n_err++;
      $display("FAIL full_reset: got flag=%b count=%0d want flag=0 count=0",
               flag2, dut16.u_counter.count_q);
    end
    rst2_n  = 1'b1;
    enable2 = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      logic       exp_flag;
      logic [3:0] exp_cnt;
      tick();
      exp_flag = (k % 16 == 0);
      exp_cnt  = 4'(k % 16);
      n_cmp++;
      if (flag2 !== exp_flag || dut16.u_counter.count_q !== exp_cnt) begin
        n_err++;
        $display("FAIL full_range[edge %0d]: got flag=%b count=%0d want flag=%b count=%0d",
                 k, flag2, dut16.u_counter.count_q, exp_flag, exp_cnt);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    rst2_n  = 1'b0;
    enable2 = 1'b0;
    #1;
    test_reset();
    test_continuous();
    test_pause();
    test_enable_drop_at_terminal();
    test_reset_mid();
    test_full_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
